byte_lane_dly_loader: RTL and testbench

//  Upstream delay-programming sequencer for the byte_lane PHY blocks. Holds a per-lane table of

---
 rtl/phy_dly_pkg.sv | 18 +
 rtl/dly_table_ram.sv | 42 ++++
 rtl/byte_lane_dly_loader.sv | 154 +++++++++++++++
 tb/tb_byte_lane_dly_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_dly_pkg.sv
// Shared definitions for the byte-lane delay programming path.
// Holds the dly_addr map boundaries and the loader FSM state encoding.
package phy_dly_pkg;

  localparam logic [4:0] DLY_ADDR_ODLY_LAST   = 5'd9;
  localparam logic [4:0] DLY_ADDR_IDLY_FIRST  = 5'd16;
  localparam logic [4:0] DLY_ADDR_IDLY_LAST   = 5'd24;
  localparam int         DLY_ENTRIES_PER_LANE = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SET,
    S_DONE
  } dly_state_e;

endpackage

// File: rtl/dly_table_ram.sv
// Delay table storage: one write port, two synchronous read ports.
//  clk_i                   clock
//  rst_i                   async active-high reset; clears only the read registers
//  we_i/waddr_i/wdata_i    write port
//  re_a_i/raddr_a_i        sequencer read; output holds while re_a_i=0
//  rdata_a_o               sequencer read data (1-cycle latency)
//  raddr_b_i/rdata_b_o     readback port, reads every cycle
// The array itself is never reset so host-programmed delays survive rst.
module dly_table_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_a_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-cycle write/read of one index returns the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_a_o <= '0;
      rdata_b_o <= '0;
    end else begin
      if (re_a_i) rdata_a_o <= mem[raddr_a_i];
      rdata_b_o <= mem[raddr_b_i];
    end
  end

endmodule

// File: rtl/byte_lane_dly_loader.sv
// Delay-programming sequencer for the byte_lane PHY blocks.
// Host fills a per-lane table of tap values; a start pulse streams every used
// entry of the selected lanes over the shared dly bus, then pulses set.
//  clk_div, rst         clock / async active-high reset
//  wr_en_i/wr_addr_i/wr_data_i   host table write ({lane, dly_addr})
//  rd_addr_i/rd_data_o  registered readback
//  start_i/lane_mask_i  sequence request and lanes to program
//  busy_o/done_o/wr_err_o        status
//  dly_data_o/dly_addr_o/ld_delay_o/set_o  byte_lane programming bus
module byte_lane_dly_loader
  import phy_dly_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                           clk_div,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [$clog2(NUM_LANES)+4:0]   wr_addr_i,
  input  logic [7:0]                     wr_data_i,
  input  logic [$clog2(NUM_LANES)+4:0]   rd_addr_i,
  output logic [7:0]                     rd_data_o,
  input  logic                           start_i,
  input  logic [NUM_LANES-1:0]           lane_mask_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           wr_err_o,
  output logic [7:0]                     dly_data_o,
  output logic [4:0]                     dly_addr_o,
  output logic [NUM_LANES-1:0]           ld_delay_o,
  output logic [NUM_LANES-1:0]           set_o
);

  localparam int AW = $clog2(NUM_LANES) + 5;
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  dly_state_e           state_q;
  logic [NUM_LANES-1:0] mask_q, ld_q, set_q;
  logic [LW-1:0]        lane_q, first_lane_d, nxt_lane_d;
  logic                 nxt_vld_d;
  logic [4:0]           addr_q, dly_addr_q;
  logic                 last_q, busy_q, done_q, wr_err_q;
  logic                 seq_re;
  logic [AW-1:0]        seq_raddr;

  // Lowest set lane of the incoming mask, and next set lane above the current one.
  always_comb begin
    first_lane_d = '0;
    nxt_vld_d    = 1'b0;
    nxt_lane_d   = lane_q;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_mask_i[i]) first_lane_d = LW'(i);
      if (mask_q[i] && (i > int'(lane_q))) begin
        nxt_vld_d  = 1'b1;
        nxt_lane_d = LW'(i);
      end
    end
  end

  // The read for an entry is issued one cycle ahead of its ld strobe; last_q
  // marks that the final entry has already been fetched.
  assign seq_re    = (state_q == S_FETCH) || ((state_q == S_LOAD) && !last_q);
  assign seq_raddr = AW'({lane_q, addr_q});

  dly_table_ram #(.DEPTH(NUM_LANES * 32), .AW(AW)) u_tbl (
    .clk_i     (clk_div),
    .rst_i     (rst),
    .we_i      (wr_en_i & ~busy_q),
    .waddr_i   (wr_addr_i),
    .wdata_i   (wr_data_i),
    .re_a_i    (seq_re),
    .raddr_a_i (seq_raddr),
    .rdata_a_o (dly_data_o),
    .raddr_b_i (rd_addr_i),
    .rdata_b_o (rd_data_o)
  );

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      lane_q     <= '0;
      addr_q     <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      ld_q       <= '0;
      set_q      <= '0;
      dly_addr_q <= '0;
    end else begin
      wr_err_q <= wr_en_i & busy_q;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mask_q <= lane_mask_i;
            busy_q <= 1'b1;
            lane_q <= first_lane_d;
            addr_q <= '0;
            last_q <= 1'b0;
            if (lane_mask_i == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH, S_LOAD: begin
          if (seq_re) begin
            ld_q       <= NUM_LANES'(1) << lane_q;
            dly_addr_q <= addr_q;
            state_q    <= S_LOAD;
            if (addr_q == DLY_ADDR_ODLY_LAST) begin
              addr_q <= DLY_ADDR_IDLY_FIRST;
            end else if (addr_q == DLY_ADDR_IDLY_LAST) begin
              if (nxt_vld_d) begin
                lane_q <= nxt_lane_d;
                addr_q <= '0;
              end else begin
                last_q <= 1'b1;
              end
            end else begin
              addr_q <= addr_q + 5'd1;
            end
          end else begin
            ld_q    <= '0;
            set_q   <= mask_q;
            last_q  <= 1'b0;
            state_q <= S_SET;
          end
        end
        S_SET: begin
          set_q   <= '0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_err_o   = wr_err_q;
  assign ld_delay_o = ld_q;
  assign set_o      = set_q;
  assign dly_addr_o = dly_addr_q;

endmodule

// File: tb/tb_byte_lane_dly_loader.sv
module tb_byte_lane_dly_loader;
  localparam int NL = 2;

  logic         clk_div = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic [5:0]   rd_addr = '0;
  logic [7:0]   rd_data;
  logic         start = 1'b0;
  logic [NL-1:0] lane_mask = '0;
  logic         busy, done, wr_err;
  logic [7:0]   dly_data;
  logic [4:0]   dly_addr;
  logic [NL-1:0] ld_delay, set;

  byte_lane_dly_loader #(.NUM_LANES(NL)) dut (
    .clk_div(clk_div), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .start_i(start), .lane_mask_i(lane_mask),
    .busy_o(busy), .done_o(done), .wr_err_o(wr_err),
    .dly_data_o(dly_data), .dly_addr_o(dly_addr),
    .ld_delay_o(ld_delay), .set_o(set)
  );

  always #5 clk_div = ~clk_div;

  int edge_n = 0;
  always @(posedge clk_div) edge_n <= edge_n + 1;

  localparam int K_LD = 0, K_SET = 1, K_DONE = 2;
  typedef struct {
    int         kind;
    int         at;
    logic [7:0] val;
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] tbl [64];
  int checks = 0, errs = 0, n_ld = 0, n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic step();
    @(negedge clk_div);
    #1;
  endtask

  // Expected bus activity for a start launched after edge t0.
  task automatic push_seq(input logic [NL-1:0] m, input int t0);
    int   k, n;
    exp_t e;
    k = 0;
    n = 0;
    for (int l = 0; l < NL; l++) begin
      if (m[l]) begin
        n++;
        for (int a = 0; a < 25; a++) begin
          if (a > 9 && a < 16) continue;
          k++;
          e.kind = K_LD; e.at = t0 + 1 + k;
          e.val  = 8'(1 << l); e.addr = 5'(a); e.data = tbl[l * 32 + a];
          sbq.push_back(e);
        end
      end
    end
    e.addr = '0; e.data = '0;
    if (n > 0) begin
      e.kind = K_SET; e.at = t0 + 2 + 19 * n; e.val = 8'(m);
      sbq.push_back(e);
      e.kind = K_DONE; e.at = t0 + 3 + 19 * n; e.val = '0;
    end else begin
      e.kind = K_DONE; e.at = t0 + 1; e.val = '0;
    end
    sbq.push_back(e);
  endtask

  always @(negedge clk_div) begin
    exp_t e;
    if (!rst) begin
      if (ld_delay != '0) begin
        n_ld++;
        if (sbq.size() == 0) chk("ld_extra", 32'(ld_delay), 0);
        else begin
          e = sbq.pop_front();
          chk("ld_kind", K_LD, e.kind);
          chk("ld_edge", edge_n, e.at);
          chk("ld_lane", 32'(ld_delay), 32'(e.val));
          chk("ld_addr", 32'(dly_addr), 32'(e.addr));
          chk("ld_data", 32'(dly_data), 32'(e.data));
        end
      end
      if (set != '0) begin
        if (sbq.size() == 0) chk("set_extra", 32'(set), 0);
        else begin
          e = sbq.pop_front();
          chk("set_kind", K_SET, e.kind);
          chk("set_edge", edge_n, e.at);
          chk("set_val", 32'(set), 32'(e.val));
        end
      end
      if (done) begin
        n_done++;
        if (sbq.size() == 0) chk("done_extra", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("done_kind", K_DONE, e.kind);
          chk("done_edge", edge_n, e.at);
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) step();
    if (sbq.size() != 0) begin
      chk("seq_timeout", sbq.size(), 0);
      sbq.delete();
    end
    step();
    chk("busy_fall", busy, 0);
  endtask

  task automatic launch(input logic [NL-1:0] m);
    push_seq(m, edge_n);
    start = 1'b1;
    lane_mask = m;
    step();
    start = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    tbl[a] = d;
  endtask

  initial begin
    int d0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_ld", 32'(ld_delay), 0);
    chk("rst_set", 32'(set), 0);
    chk("rst_dly_data", 32'(dly_data), 0);
    chk("rst_dly_addr", 32'(dly_addr), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    step();
    rst = 1'b0;
    step();

    // Table fill and readback sweep
    for (int a = 0; a < 32; a++) wr(a, 8'(a + 8'h40));
    for (int a = 0; a < 32; a++) wr(32 + a, 8'((a * 7 + 8'h11) ^ 8'ha0));
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      step();
      chk("readback", 32'(rd_data), 32'(tbl[a]));
    end

    // Same-cycle write and read of one index returns the old value
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'ha5; rd_addr = 6'd5;
    step();
    wr_en = 1'b0;
    chk("rdw_old", 32'(rd_data), 32'(tbl[5]));
    tbl[5] = 8'ha5;
    step();
    chk("rdw_new", 32'(rd_data), 32'ha5);

    launch(2'b01); wait_done();
    launch(2'b11); wait_done();
    launch(2'b10); wait_done();
    launch(2'b00); wait_done();

    // Write and start while busy: write dropped, start ignored
    d0 = n_done;
    launch(2'b11);
    repeat (4) step();
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hee;
    start = 1'b1; lane_mask = 2'b10;
    step();
    wr_en = 1'b0; start = 1'b0;
    chk("wr_err_pulse", wr_err, 1);
    step();
    chk("wr_err_single", wr_err, 0);
    wait_done();
    repeat (5) step();
    chk("single_done", n_done - d0, 1);
    rd_addr = 6'd3;
    step();
    chk("busy_wr_dropped", 32'(rd_data), 32'(tbl[3]));

    // Reset in the middle of a sequence
    d0 = n_ld;
    launch(2'b11);
    for (int i = 0; i < 100 && (n_ld - d0) < 7; i++) step();
    chk("rst_seq_reached", 32'((n_ld - d0) >= 7), 1);
    rst = 1'b1;
    #1;
    chk("midrst_ld", 32'(ld_delay), 0);
    chk("midrst_set", 32'(set), 0);
    chk("midrst_busy", busy, 0);
    sbq.delete();
    step();
    step();
    rst = 1'b0;
    step();
    launch(2'b11); wait_done();

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=0", edge_n);
    $fatal(1, "timeout");
  end
endmodule
